// File: rtl/addsub_pipe_if.sv
// addsub_pipe_if: operand/result valid-ready bundle for addsub_pipe
interface addsub_pipe_if #(parameter int WIDTH = 32);
    logic in_valid, in_ready, c_in, sub;
    logic [WIDTH-1:0] a, b, s;
    logic out_valid, out_ready, c_out, ovf, zero, neg;
    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, s, c_out, ovf, zero, neg
    );
    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, s, c_out, ovf, zero, neg
    );
endinterface

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined add/sub, one carry slice per stage, valid/ready handshake
module addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input logic clk,
    input logic rst,
    addsub_pipe_if.slave io
);
    localparam int SW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;
    logic adv;
    logic v_q [STAGES];
    logic c_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] bb_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic v_i [STAGES];
    logic c_i [STAGES];
    logic [WIDTH-1:0] a_i [STAGES];
    logic [WIDTH-1:0] bb_i [STAGES];
    logic [WIDTH-1:0] s_i [STAGES];
    logic [WIDTH-1:0] s_n [STAGES];
    logic [SW:0] t [STAGES];
    logic ovf_n, ovf_q, zero_q, neg_q;
    assign adv         = !v_q[L] || io.out_ready;
    assign io.in_ready = adv;
    // stage k consumes the registers of stage k-1; stage 0 takes the transformed operands
    always_comb begin
        v_i[0]  = io.in_valid;
        a_i[0]  = io.a;
        bb_i[0] = io.sub ? ~io.b : io.b;
        c_i[0]  = io.sub ^ io.c_in;
        s_i[0]  = '0;
        for (int k = 1; k < STAGES; k++) begin
            v_i[k]  = v_q[k-1];
            a_i[k]  = a_q[k-1];
            bb_i[k] = bb_q[k-1];
            c_i[k]  = c_q[k-1];
            s_i[k]  = s_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            t[k] = {1'b0, a_i[k][k*SW +: SW]} + {1'b0, bb_i[k][k*SW +: SW]} + {{SW{1'b0}}, c_i[k]};
            s_n[k] = s_i[k];
            s_n[k][k*SW +: SW] = t[k][SW-1:0];
        end
        ovf_n = (a_i[L][WIDTH-1] == bb_i[L][WIDTH-1]) && (s_n[L][WIDTH-1] != a_i[L][WIDTH-1]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]  <= 1'b0;
                c_q[k]  <= 1'b0;
                s_q[k]  <= '0;
                a_q[k]  <= '0;
                bb_q[k] <= '0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]  <= v_i[k];
                c_q[k]  <= t[k][SW];
                s_q[k]  <= s_n[k];
                a_q[k]  <= a_i[k];
                bb_q[k] <= bb_i[k];
            end
            ovf_q  <= ovf_n;
            zero_q <= s_n[L] == '0;
            neg_q  <= s_n[L][WIDTH-1];
        end
    end
    assign io.out_valid = v_q[L];
    assign io.s         = s_q[L];
    assign io.c_out     = c_q[L];
    assign io.ovf       = ovf_q;
    assign io.zero      = zero_q;
    assign io.neg       = neg_q;
endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
Parametrised, pipelined integer adder/subtractor for the RV32 datapath; the next generation of the single-cycle 32-bit ripple adder. Splits the WIDTH-bit carry chain into STAGES equal slices, one slice per clock. A valid/ready handshake supports back-pressure, and the block emits RISC-V-relevant flags (carry, signed overflow, zero, negative). Sits between the ALU operand mux and the writeback/branch-compare logic.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of STAGES
STAGES, 2, pipeline depth = number of carry slices (1..8); slice width SW = WIDTH/STAGES

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
c_in  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0: s = a+b+c_in; 1: s = a-b-c_in
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
s  output  WIDTH  result, modulo 2^WIDTH
c_out  output  1  raw carry out of MSB (sub: 1 = no borrow)
ovf  output  1  two's-complement signed overflow
zero  output  1  s == 0
neg  output  1  s[WIDTH-1]

Behaviour:
- Operand transform at accept: bb = sub ? ~b : b; cc = sub ? ~c_in : c_in. The full-width sum is a + bb + cc.
- Stage k (0..STAGES-1) adds slice k of a and bb, plus the carry from stage k-1 (stage 0 uses cc). Upper unprocessed slices of a/bb, the completed lower sum slices, sub and the sign bits travel with the beat in pipeline registers.
- ovf = (a[MSB] == bb[MSB]) && (s[MSB] != a[MSB]); zero/neg are computed from the final s. All flags are registered with s.
- Latency: a beat accepted in cycle T (in_valid && in_ready) presents out_valid=1 in cycle T+STAGES if there is no stall. Throughput is 1 beat/cycle.
- Each stage has a valid bit. The pipeline advances when adv = !out_valid || out_ready. in_ready = adv (combinational; no in_valid -> in_ready dependency).
- When adv=0, all stage registers and outputs hold. s/flags stay stable while out_valid && !out_ready.
- A beat offered while in_ready=0 is not consumed, and the source must hold it. Pipeline bubbles (in_valid=0) propagate as valid=0 and are never emitted.
- Beats emerge in acceptance order. No beat is dropped or duplicated.
- Reset, synchronous: all valid bits, out_valid, s, c_out, ovf, zero and neg go to 0. in_ready reads 1 in the first cycle after reset. rst asserted mid-operation discards every in-flight beat. Outputs are 0 on the next edge regardless of out_ready. rst overrides a simultaneous accept.
- Simultaneous accept and emit with a full pipeline (out_ready=1, in_valid=1) must sustain full rate with no bubble.
- STAGES=1 degenerates to one registered full-width adder with latency 1.
- Data registers without a valid bit may hold stale values. Only s/flags with out_valid=1 are architecturally meaningful, apart from the reset value.

Test Plan:
- WIDTH=32, STAGES=2, add, c_in=0: a=00000001, b=00000004 -> after 2 cycles s=00000005, c_out=0, ovf=0, zero=0, neg=0.
- Add a=00000001, b=FFFFFFFF -> s=00000000, c_out=1, zero=1, ovf=0. Then a=0000FFFF, b=00000001 -> s=00010000, which checks the carry crossing the slice boundary.
- Add a=7FFFFFFF, b=00000001 -> s=80000000, ovf=1, neg=1, c_out=0. Then sub a=00000005, b=00000007, c_in=0 -> s=FFFFFFFE, c_out=0, neg=1, ovf=0. Then sub a=80000000, b=00000001 -> s=7FFFFFFF, ovf=1, c_out=1.
- Back-pressure: 4 back-to-back beats (1+1, 2+2, 3+3, 4+4) with out_ready=0 from cycle 2 for 3 cycles. in_ready drops while stalled and s holds 2 until accepted. The outputs are then 2, 4, 6, 8 in order, with none lost or duplicated, resuming at 1 beat/cycle.
- Reset mid-flight: accept 2 beats, assert rst for 1 cycle -> out_valid=0, s=0 next cycle. Neither beat ever appears, and in_ready=1 after reset.
- Parameter sweep (WIDTH=8/STAGES=4, WIDTH=64/STAGES=8, WIDTH=32/STAGES=1): 1000 random beats with random in_valid/out_ready, scoreboarded against a behavioural model of a+/-b+/-c_in and all four flags. Latency is exactly STAGES cycles when unstalled.
